prod_accum4: RTL and testbench
==============================

PROD_ACCUM4 -- requirements
Module: prod_accum4

Interface
REQ-001 Parameter MAX_TERMS, default 16, meaning: maximum number of products per frame (legal range 1..16).
REQ-002 Parameter ACC_W, default 12, meaning: accumulator width (8 + log2(MAX_TERMS)).
REQ-003 clk  input  1  single clock; all state changes on its rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 in_valid  input  1  product beat present.
REQ-006 in_ready  output  1  block accepts a beat this cycle.
REQ-007 Z  input  7  low 7 bits of the unsigned 4x4 product.
REQ-008 Cout  input  1  product bit 7; the full product is {Cout,Z}.
REQ-009 in_last  input  1  marks the final beat of a frame.
REQ-010 out_valid  output  1  frame result available.
REQ-011 out_ready  input  1  consumer accepts the result.
REQ-012 acc  output  ACC_W  frame sum of products.
REQ-013 terms  output  5  number of beats in the frame (1..MAX_TERMS).
REQ-014 range_err  output  1  a beat in the frame had {Cout,Z} > 225.

Function
REQ-015 The block SHALL use the states IDLE, ACCUM and DONE.
REQ-016 A beat SHALL transfer only on a cycle where in_valid=1 and in_ready=1.
REQ-017 in_ready SHALL be 1 in IDLE and ACCUM and 0 in DONE.
REQ-018 In IDLE, a transfer SHALL load acc={4'b0,Cout,Z} and terms=1, then move to ACCUM or to DONE.
REQ-019 In ACCUM, a transfer SHALL set acc=acc+{Cout,Z} (zero-extended) and terms=terms+1.
REQ-020 The state SHALL move to DONE on the transfer that has in_last=1 or that makes terms equal MAX_TERMS, whichever comes first.
REQ-021 A MAX_TERMS-forced close SHALL produce the same result as an in_last close; the next beat starts a new frame.
REQ-022 range_err SHALL be set when any beat of the frame has a product > 225, cleared when a new frame starts, and held through DONE.
REQ-023 out_valid SHALL be 1 exactly in DONE, and acc, terms and range_err SHALL stay stable while out_valid=1.
REQ-024 In DONE with out_ready=1, the state SHALL go to IDLE on the next edge; with out_ready=0, the state SHALL stay in DONE.
REQ-025 A beat SHALL NOT be accepted on the cycle DONE exits, which gives a minimum one-cycle bubble between frames.
REQ-026 Latency SHALL be: out_valid asserts on the cycle after the closing transfer.
REQ-027 The accumulator SHALL NOT wrap (16 x 255 = 4080 < 4096), and no saturation logic SHALL exist.
REQ-028 in_valid=1 in DONE SHALL be ignored, and the upstream source SHALL hold its beat.

Reset
REQ-029 rst=1 SHALL force state=IDLE, acc=0, terms=0, range_err=0 and out_valid=0 on the next edge.
REQ-030 in_ready SHALL be 1 in the first cycle after reset is released.
REQ-031 rst during ACCUM or DONE SHALL discard the partial or pending frame, and no out_valid SHALL follow.
REQ-032 rst SHALL take priority over a simultaneous transfer or out_ready.

Structure
REQ-033 The state encoding, MAX_PRODUCT=225 and the default ACC_W/MAX_TERMS SHALL live in the shared multiplier package.
REQ-034 The block SHALL be a single module with no sub-modules: one state register, accumulator, term counter and error flag.

Verification
REQ-035 Reset, then beats 210,110,156 with in_last on the third and out_ready=1 -> out_valid one cycle later, acc=476, terms=3, range_err=0.
REQ-036 16 beats of 225 with no in_last -> close on the 16th beat, acc=3600, terms=16; the 17th beat starts a new frame with terms=1.
REQ-037 Single beat {Cout,Z}=8'hF0 (240) with in_last -> acc=240, terms=1, range_err=1; the next frame of beat 56 with in_last -> range_err=0.
REQ-038 Hold out_ready=0 for 5 cycles while in_valid=1 -> in_ready=0, acc unchanged, no beat lost; the beat is accepted after the out_ready pulse plus the bubble.
REQ-039 Assert rst during the second beat of a frame -> out_valid never asserts, all outputs are 0 next cycle, and the following frame of beat 90 returns acc=90.
REQ-040 Random valid/ready throttling over 1000 frames -> each acc and terms equals the scoreboard sum and count.

Source files
------------

// File: rtl/prod_accum4_pkg.sv
// prod_accum4_pkg: state encoding, product limit and default sizing for the product accumulator
package prod_accum4_pkg;
  typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;
  localparam logic [7:0] MAX_PRODUCT = 8'd225;
  localparam int DEF_MAX_TERMS = 16;
  localparam int DEF_ACC_W = 12;
endpackage

// File: rtl/prod_accum4.sv
// prod_accum4: sums {Cout,Z} product beats per frame (in_valid/in_ready in, out_valid/out_ready with acc/terms/range_err out)
module prod_accum4
  import prod_accum4_pkg::*;
#(
  parameter int MAX_TERMS = DEF_MAX_TERMS,
  parameter int ACC_W = DEF_ACC_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [6:0]       Z,
  input  logic             Cout,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] acc,
  output logic [4:0]       terms,
  output logic             range_err
);
  state_t state_q, state_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [4:0] terms_q, terms_d, terms_nx;
  logic err_q, err_d;
  logic [7:0] prod;
  logic xfer, first, close;
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      acc_q <= '0;
      terms_q <= '0;
      err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q <= acc_d;
      terms_q <= terms_d;
      err_q <= err_d;
    end
  end
  always_comb begin
    prod = {Cout, Z};
    xfer = in_valid && state_q != DONE;
    first = state_q == IDLE;
    terms_nx = first ? 5'd1 : terms_q + 5'd1;
    close = in_last || terms_nx == 5'(MAX_TERMS);
    state_d = state_q == DONE ? (out_ready ? IDLE : DONE) : xfer ? (close ? DONE : ACCUM) : state_q;
    acc_d = xfer ? (first ? ACC_W'(prod) : acc_q + ACC_W'(prod)) : acc_q;
    terms_d = xfer ? terms_nx : terms_q;
    err_d = xfer ? (prod > MAX_PRODUCT || (!first && err_q)) : err_q;
  end
  always_comb begin
    in_ready = state_q != DONE;
    out_valid = state_q == DONE;
  end
  assign acc = acc_q;
  assign terms = terms_q;
  assign range_err = err_q;
endmodule

// File: tb/tb_prod_accum4.sv
// tb_prod_accum4: directed and randomly throttled frames checked against a scoreboard queue
module tb_prod_accum4;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic in_valid = 1'b0;
  logic in_ready;
  logic [6:0] Z = '0;
  logic Cout = 1'b0;
  logic in_last = 1'b0;
  logic out_valid;
  logic out_ready = 1'b1;
  logic [11:0] acc;
  logic [4:0] terms;
  logic range_err;
  typedef struct {int acc; int terms; int err;} exp_t;
  exp_t q[$];
  int checks = 0;
  int errors = 0;
  int m_sum = 0;
  int m_cnt = 0;
  int m_err = 0;
  bit rand_ready = 1'b0;
  bit hs;
  prod_accum4 dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .Z(Z), .Cout(Cout),
    .in_last(in_last), .out_valid(out_valid), .out_ready(out_ready), .acc(acc),
    .terms(terms), .range_err(range_err)
  );
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0d expected %0d", name, obs, exp);
    end
  endtask
  task automatic model(input int p, input logic last);
    if (m_cnt == 0) begin
      m_sum = 0;
      m_err = 0;
    end
    m_sum += p;
    m_cnt++;
    if (p > 225) m_err = 1;
    if (last || m_cnt == 16) begin
      q.push_back(exp_t'{m_sum, m_cnt, m_err});
      m_cnt = 0;
    end
  endtask
  task automatic mon();
    if (!rst && out_valid) begin
      if (q.size() == 0) chk("spurious_out_valid", 32'(out_valid), 0);
      else begin
        chk("acc", 32'(acc), q[0].acc);
        chk("terms", 32'(terms), q[0].terms);
        chk("range_err", 32'(range_err), q[0].err);
        if (out_ready) void'(q.pop_front());
      end
    end
  endtask
  task automatic tick(output bit t);
    @(negedge clk);
    t = in_valid && in_ready && !rst;
    mon();
    @(posedge clk);
    #1;
    if (rand_ready) out_ready = 1'($urandom_range(0, 1));
  endtask
  task automatic send(input int p, input logic last);
    int n;
    bit t;
    in_valid = 1'b1;
    {Cout, Z} = 8'(p);
    in_last = last;
    n = 0;
    do begin
      tick(t);
      n++;
    end while (!t && n < 300);
    chk("send_handshake", 32'(t), 1);
    if (t) model(p, last);
    in_valid = 1'b0;
    in_last = 1'b0;
  endtask
  initial begin
    int len, n;
    repeat (3) tick(hs);
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_acc", 32'(acc), 0);
    chk("rst_terms", 32'(terms), 0);
    chk("rst_range_err", 32'(range_err), 0);
    rst = 1'b0;
    chk("rst_in_ready", 32'(in_ready), 1);
    send(210, 0);
    send(110, 0);
    send(156, 1);
    chk("latency_ov", 32'(out_valid), 1);
    chk("sum3_acc", 32'(acc), 476);
    chk("sum3_terms", 32'(terms), 3);
    tick(hs);
    for (int i = 0; i < 16; i++) send(225, 0);
    chk("max_ov", 32'(out_valid), 1);
    chk("max_acc", 32'(acc), 3600);
    chk("max_terms", 32'(terms), 16);
    send(225, 1);
    chk("after_max_terms", 32'(terms), 1);
    send(240, 1);
    chk("err_set", 32'(range_err), 1);
    chk("err_acc", 32'(acc), 240);
    send(56, 1);
    chk("err_clear", 32'(range_err), 0);
    tick(hs);
    out_ready = 1'b0;
    send(100, 1);
    in_valid = 1'b1;
    {Cout, Z} = 8'd77;
    in_last = 1'b1;
    repeat (5) begin
      tick(hs);
      chk("stall_hs", 32'(hs), 0);
      chk("stall_in_ready", 32'(in_ready), 0);
      chk("stall_acc", 32'(acc), 100);
    end
    out_ready = 1'b1;
    tick(hs);
    chk("exit_no_accept", 32'(hs), 0);
    out_ready = 1'b0;
    chk("bubble_in_ready", 32'(in_ready), 1);
    tick(hs);
    chk("held_beat_hs", 32'(hs), 1);
    if (hs) model(77, 1);
    in_valid = 1'b0;
    in_last = 1'b0;
    chk("held_beat_acc", 32'(acc), 77);
    out_ready = 1'b1;
    tick(hs);
    send(90, 0);
    in_valid = 1'b1;
    {Cout, Z} = 8'd50;
    rst = 1'b1;
    tick(hs);
    rst = 1'b0;
    in_valid = 1'b0;
    m_cnt = 0;
    chk("mid_rst_ov", 32'(out_valid), 0);
    chk("mid_rst_acc", 32'(acc), 0);
    chk("mid_rst_terms", 32'(terms), 0);
    chk("mid_rst_err", 32'(range_err), 0);
    repeat (4) tick(hs);
    send(90, 1);
    chk("post_rst_acc", 32'(acc), 90);
    rand_ready = 1'b1;
    for (int f = 0; f < 1000; f++) begin
      len = $urandom_range(1, 20);
      for (int i = 0; i < len; i++) begin
        send($urandom_range(0, 255), i == len - 1);
        if ($urandom_range(0, 3) == 0) tick(hs);
      end
    end
    rand_ready = 1'b0;
    out_ready = 1'b1;
    n = 0;
    while (q.size() > 0 && n < 100) begin
      tick(hs);
      n++;
    end
    chk("drain_empty", 32'(q.size()), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
